// File: rtl/jtag_ir_gen_pkg.sv
// Opcode map, select/command index enums and the instruction decode function
// shared by the JTAG IR decoder and its command pulser.
package jtag_ir_gen_pkg;

  localparam int OP_W  = 5;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;

  localparam logic [OP_W-1:0] OP_IDCODE        = 5'h01;
  localparam logic [OP_W-1:0] OP_CONFIGURATION = 5'h02;
  localparam logic [OP_W-1:0] OP_EXTESTSER     = 5'h03;
  localparam logic [OP_W-1:0] OP_EXTESTDAC     = 5'h04;
  localparam logic [OP_W-1:0] OP_SAMPLE        = 5'h05;
  localparam logic [OP_W-1:0] OP_USERCODE      = 5'h06;
  localparam logic [OP_W-1:0] OP_STATUS        = 5'h07;
  localparam logic [OP_W-1:0] OP_DEBUG         = 5'h08;
  localparam logic [OP_W-1:0] OP_TRACE         = 5'h09;
  localparam logic [OP_W-1:0] OP_CALIB         = 5'h0A;
  localparam logic [OP_W-1:0] OP_PROG          = 5'h0B;
  localparam logic [OP_W-1:0] OP_ADDR          = 5'h0C;
  localparam logic [OP_W-1:0] OP_DATA          = 5'h0D;
  localparam logic [OP_W-1:0] OP_WRREG         = 5'h10;
  localparam logic [OP_W-1:0] OP_RDREG         = 5'h11;
  localparam logic [OP_W-1:0] OP_ECR           = 5'h12;
  localparam logic [OP_W-1:0] OP_RSTCORE       = 5'h13;
  localparam logic [OP_W-1:0] OP_HALT          = 5'h14;
  localparam logic [OP_W-1:0] OP_RESUME        = 5'h15;
  localparam logic [OP_W-1:0] OP_STEP          = 5'h16;
  localparam logic [OP_W-1:0] OP_FLUSH         = 5'h17;
  localparam logic [OP_W-1:0] OP_BYPASS        = 5'h1F;

  typedef enum logic [IDX_W-1:0] {
    SEL_BYPASS        = 4'd0,
    SEL_IDCODE        = 4'd1,
    SEL_CONFIGURATION = 4'd2,
    SEL_BSR_SER       = 4'd3,
    SEL_BSR_DAC       = 4'd4,
    SEL_SAMPLE        = 4'd5,
    SEL_USERCODE      = 4'd6,
    SEL_STATUS        = 4'd7,
    SEL_DEBUG         = 4'd8,
    SEL_TRACE         = 4'd9,
    SEL_CALIB         = 4'd10,
    SEL_PROG          = 4'd11,
    SEL_ADDR          = 4'd12,
    SEL_DATA          = 4'd13
  } sel_idx_e;

  typedef enum logic [IDX_W-1:0] {
    CMD_WRREG   = 4'd0,
    CMD_RDREG   = 4'd1,
    CMD_ECR     = 4'd2,
    CMD_RSTCORE = 4'd3,
    CMD_HALT    = 4'd4,
    CMD_RESUME  = 4'd5,
    CMD_STEP    = 4'd6,
    CMD_FLUSH   = 4'd7
  } cmd_idx_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_state_e;

  typedef struct packed {
    logic             valid;
    logic             is_cmd;
    logic [IDX_W-1:0] index;
    logic             extest;
  } ir_dec_t;

  function automatic ir_dec_t sel_hit(input logic [IDX_W-1:0] idx, input logic ext);
    ir_dec_t d;
    d.valid  = 1'b1;
    d.is_cmd = 1'b0;
    d.index  = idx;
    d.extest = ext;
    return d;
  endfunction

  function automatic ir_dec_t cmd_hit(input logic [IDX_W-1:0] idx);
    ir_dec_t d;
    d.valid  = 1'b1;
    d.is_cmd = 1'b1;
    d.index  = idx;
    d.extest = 1'b0;
    return d;
  endfunction

  // Unlisted opcodes come back with valid=0 and are treated as illegal.
  function automatic ir_dec_t ir_decode(input logic [OP_W-1:0] op);
    ir_dec_t d;
    d = '0;
    case (op)
      OP_BYPASS:        d = sel_hit(SEL_BYPASS, 1'b0);
      OP_IDCODE:        d = sel_hit(SEL_IDCODE, 1'b0);
      OP_CONFIGURATION: d = sel_hit(SEL_CONFIGURATION, 1'b0);
      OP_EXTESTSER:     d = sel_hit(SEL_BSR_SER, 1'b1);
      OP_EXTESTDAC:     d = sel_hit(SEL_BSR_DAC, 1'b1);
      OP_SAMPLE:        d = sel_hit(SEL_SAMPLE, 1'b0);
      OP_USERCODE:      d = sel_hit(SEL_USERCODE, 1'b0);
      OP_STATUS:        d = sel_hit(SEL_STATUS, 1'b0);
      OP_DEBUG:         d = sel_hit(SEL_DEBUG, 1'b0);
      OP_TRACE:         d = sel_hit(SEL_TRACE, 1'b0);
      OP_CALIB:         d = sel_hit(SEL_CALIB, 1'b0);
      OP_PROG:          d = sel_hit(SEL_PROG, 1'b0);
      OP_ADDR:          d = sel_hit(SEL_ADDR, 1'b0);
      OP_DATA:          d = sel_hit(SEL_DATA, 1'b0);
      OP_WRREG:         d = cmd_hit(CMD_WRREG);
      OP_RDREG:         d = cmd_hit(CMD_RDREG);
      OP_ECR:           d = cmd_hit(CMD_ECR);
      OP_RSTCORE:       d = cmd_hit(CMD_RSTCORE);
      OP_HALT:          d = cmd_hit(CMD_HALT);
      OP_RESUME:        d = cmd_hit(CMD_RESUME);
      OP_STEP:          d = cmd_hit(CMD_STEP);
      OP_FLUSH:         d = cmd_hit(CMD_FLUSH);
      default:          d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/jtag_cmd_pulser.sv
// Two-state command pulser: a request accepted in IDLE drives one CMD line
// high for exactly CMD_PULSE_CYCLES cycles; requests seen while pulsing are ignored.
module jtag_cmd_pulser
  import jtag_ir_gen_pkg::*;
#(
  parameter int N_CMD            = 8,
  parameter int CMD_PULSE_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_req,
  input  logic [IDX_W-1:0] i_idx,
  output logic [N_CMD-1:0] o_cmd,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CMD_PULSE_CYCLES - 1);

  pulse_state_e     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N_CMD-1:0] r_cmd;
  logic [N_CMD-1:0] w_onehot;

  generate
    for (genvar gi = 0; gi < N_CMD; gi++) begin : g_onehot
      assign w_onehot[gi] = (i_idx == IDX_W'(gi));
    end
  endgenerate

  // r_cnt holds the number of high cycles still to come after the current one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cmd   <= '0;
    end else if (i_clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cmd   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_state <= ST_PULSE;
            r_cnt   <= CNT_LOAD;
            r_cmd   <= w_onehot;
          end
        end
        ST_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_cmd   <= '0;
        end
      endcase
    end
  end

  assign o_cmd  = r_cmd;
  assign o_busy = (r_state == ST_PULSE);

endmodule

// File: rtl/jtag_ir_decoder_gen.sv
// JTAG instruction decoder: turns each UPDATE_IR strobe into a one-hot data
// register select, EXTEST mode, a command pulse, or an illegal-opcode event.
module jtag_ir_decoder_gen
  import jtag_ir_gen_pkg::*;
#(
  parameter int IR_WIDTH         = 5,
  parameter int N_SEL            = 14,
  parameter int N_CMD            = 8,
  parameter int CMD_PULSE_CYCLES = 2,
  parameter int ILL_CNT_WIDTH    = 8
) (
  input  logic                     i_tck,
  input  logic                     i_trst_n,
  input  logic [IR_WIDTH-1:0]      i_opcode,
  input  logic                     i_update_ir,
  input  logic                     i_tlr,
  output logic [N_SEL-1:0]         o_sel,
  output logic                     o_extest,
  output logic [N_CMD-1:0]         o_cmd,
  output logic                     o_cmd_busy,
  output logic                     o_illegal,
  output logic                     o_dropped,
  output logic [ILL_CNT_WIDTH-1:0] o_ill_cnt
);

  localparam logic [N_SEL-1:0] SEL_RST = N_SEL'(1) << SEL_BYPASS;

  logic                     r_rst_meta;
  logic                     r_rst_sync;
  logic                     w_rst_n;
  logic                     w_upper_zero;
  ir_dec_t                  w_dec;
  logic                     w_in_range;
  logic                     w_mapped;
  logic                     w_cmd_req;
  logic                     w_busy;
  logic [IDX_W-1:0]         w_sel_idx;
  logic [N_SEL-1:0]         w_sel_next;
  logic                     w_extest_next;
  logic [N_SEL-1:0]         r_sel;
  logic                     r_extest;
  logic                     r_illegal;
  logic                     r_dropped;
  logic [ILL_CNT_WIDTH-1:0] r_ill_cnt;

  // Assertion of TRSTn propagates at once; release takes two TCK edges.
  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // Opcodes wider than the 5-bit map are only recognised with zero upper bits.
  generate
    if (IR_WIDTH > OP_W) begin : g_wide_ir
      assign w_upper_zero = ~|i_opcode[IR_WIDTH-1:OP_W];
    end else begin : g_narrow_ir
      assign w_upper_zero = 1'b1;
    end
  endgenerate

  assign w_dec      = ir_decode(i_opcode[OP_W-1:0]);
  assign w_in_range = w_dec.is_cmd ? (32'(w_dec.index) < N_CMD)
                                   : (32'(w_dec.index) < N_SEL);
  assign w_mapped   = w_dec.valid & w_upper_zero & w_in_range;
  assign w_cmd_req  = i_update_ir & ~i_tlr & w_mapped & w_dec.is_cmd;

  assign w_sel_idx     = (w_mapped & ~w_dec.is_cmd) ? w_dec.index : SEL_BYPASS;
  assign w_extest_next = w_mapped & ~w_dec.is_cmd & w_dec.extest;

  generate
    for (genvar gi = 0; gi < N_SEL; gi++) begin : g_sel
      assign w_sel_next[gi] = (w_sel_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge i_tck or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sel     <= SEL_RST;
      r_extest  <= 1'b0;
      r_illegal <= 1'b0;
      r_dropped <= 1'b0;
      r_ill_cnt <= '0;
    end else if (i_tlr) begin
      r_sel     <= SEL_RST;
      r_extest  <= 1'b0;
      r_illegal <= 1'b0;
      r_dropped <= 1'b0;
      r_ill_cnt <= '0;
    end else if (i_update_ir) begin
      r_sel    <= w_sel_next;
      r_extest <= w_extest_next;
      if (!w_mapped) begin
        r_illegal <= 1'b1;
        if (r_ill_cnt != '1) begin
          r_ill_cnt <= r_ill_cnt + ILL_CNT_WIDTH'(1);
        end
      end
      if (w_cmd_req && w_busy) begin
        r_dropped <= 1'b1;
      end
    end
  end

  jtag_cmd_pulser #(
    .N_CMD            (N_CMD),
    .CMD_PULSE_CYCLES (CMD_PULSE_CYCLES)
  ) u_pulser (
    .i_clk   (i_tck),
    .i_rst_n (w_rst_n),
    .i_clr   (i_tlr),
    .i_req   (w_cmd_req),
    .i_idx   (w_dec.index),
    .o_cmd   (o_cmd),
    .o_busy  (w_busy)
  );

  assign o_sel      = r_sel;
  assign o_extest   = r_extest;
  assign o_cmd_busy = w_busy;
  assign o_illegal  = r_illegal;
  assign o_dropped  = r_dropped;
  assign o_ill_cnt  = r_ill_cnt;

endmodule

// File: tb/tb_jtag_ir_decoder_gen.sv
// Directed plus randomized check of jtag_ir_decoder_gen against a cycle-level
// behavioural model of the instruction map, pulse timing and sticky flags.
module tb_jtag_ir_decoder_gen;

  localparam int IRW = 5;
  localparam int NS  = 14;
  localparam int NC  = 8;
  localparam int P   = 2;
  localparam int ICW = 8;

  logic           i_tck;
  logic           i_trst_n;
  logic [IRW-1:0] i_opcode;
  logic           i_update_ir;
  logic           i_tlr;
  logic [NS-1:0]  o_sel;
  logic           o_extest;
  logic [NC-1:0]  o_cmd;
  logic           o_cmd_busy;
  logic           o_illegal;
  logic           o_dropped;
  logic [ICW-1:0] o_ill_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: selected register, pulse cycles remaining, flags.
  int m_sel_idx, m_ext, m_remain, m_k, m_illegal, m_dropped, m_ill, m_hold;

  jtag_ir_decoder_gen #(
    .IR_WIDTH(IRW), .N_SEL(NS), .N_CMD(NC), .CMD_PULSE_CYCLES(P), .ILL_CNT_WIDTH(ICW)
  ) dut (
    .i_tck(i_tck), .i_trst_n(i_trst_n), .i_opcode(i_opcode), .i_update_ir(i_update_ir),
    .i_tlr(i_tlr), .o_sel(o_sel), .o_extest(o_extest), .o_cmd(o_cmd),
    .o_cmd_busy(o_cmd_busy), .o_illegal(o_illegal), .o_dropped(o_dropped),
    .o_ill_cnt(o_ill_cnt)
  );

  initial i_tck = 1'b0;
  always #5 i_tck = ~i_tck;

  // kind: 0 unmapped, 1 register select, 2 command
  function automatic void classify(input int op, output int kind, output int idx, output int ext);
    kind = 0; idx = 0; ext = 0;
    if (op == 31) begin
      kind = 1; idx = 0;
    end else if (op >= 1 && op <= 13) begin
      kind = 1; idx = op; ext = (op == 3 || op == 4) ? 1 : 0;
    end else if (op >= 16 && op <= 23) begin
      kind = 2; idx = op - 16;
    end
  endfunction

  task automatic model_reset();
    m_sel_idx = 0; m_ext = 0; m_remain = 0; m_k = 0;
    m_illegal = 0; m_dropped = 0; m_ill = 0;
  endtask

  task automatic model_edge(input int op, input logic upd, input logic tlr);
    int kind, idx, ext, was_busy;
    if (!i_trst_n) begin
      model_reset();
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (tlr) begin
      model_reset();
    end else begin
      was_busy = (m_remain > 0);
      if (m_remain > 0) m_remain--;
      if (upd) begin
        classify(op, kind, idx, ext);
        m_sel_idx = (kind == 1) ? idx : 0;
        m_ext     = (kind == 1) ? ext : 0;
        if (kind == 2) begin
          if (was_busy) m_dropped = 1;
          else begin m_remain = P; m_k = idx; end
        end else if (kind == 0) begin
          m_illegal = 1;
          if (m_ill < 255) m_ill++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [NS-1:0]  e_sel;
    logic [NC-1:0]  e_cmd;
    logic [ICW-1:0] e_cnt;
    e_sel = NS'(1) << m_sel_idx;
    e_cmd = (m_remain > 0) ? (NC'(1) << m_k) : '0;
    e_cnt = ICW'(m_ill);
    checks++;
    assert (o_sel === e_sel) else begin
      failures++; $error("FAIL %s sel got=%h exp=%h", tag, o_sel, e_sel);
    end
    checks++;
    assert (o_extest === 1'(m_ext)) else begin
      failures++; $error("FAIL %s extest got=%b exp=%0d", tag, o_extest, m_ext);
    end
    checks++;
    assert (o_cmd === e_cmd) else begin
      failures++; $error("FAIL %s cmd got=%h exp=%h", tag, o_cmd, e_cmd);
    end
    checks++;
    assert (o_cmd_busy === 1'(m_remain > 0)) else begin
      failures++; $error("FAIL %s busy got=%b exp=%0d", tag, o_cmd_busy, m_remain > 0);
    end
    checks++;
    assert (o_illegal === 1'(m_illegal)) else begin
      failures++; $error("FAIL %s illegal got=%b exp=%0d", tag, o_illegal, m_illegal);
    end
    checks++;
    assert (o_dropped === 1'(m_dropped)) else begin
      failures++; $error("FAIL %s dropped got=%b exp=%0d", tag, o_dropped, m_dropped);
    end
    checks++;
    assert (o_ill_cnt === e_cnt) else begin
      failures++; $error("FAIL %s ill_cnt got=%0d exp=%0d", tag, o_ill_cnt, e_cnt);
    end
  endtask

  // Called at a falling edge: drive, clock, advance model, check at next falling edge.
  task automatic cycle(input int op, input logic upd, input logic tlr, input string tag);
    i_opcode = IRW'(op); i_update_ir = upd; i_tlr = tlr;
    @(posedge i_tck);
    model_edge(op, upd, tlr);
    @(negedge i_tck);
    check_all(tag);
  endtask

  initial begin
    int op;
    logic upd, tlr;
    i_trst_n = 1'b0; i_opcode = '0; i_update_ir = 1'b0; i_tlr = 1'b0;
    m_hold = 0;
    model_reset();
    @(negedge i_tck);
    repeat (3) cycle(5'h1F, 1'b1, 1'b0, "reset_hold");

    // Release; a strobe at the first edge afterwards must be ignored.
    i_trst_n = 1'b1; m_hold = 2;
    cycle(5'h10, 1'b1, 1'b0, "release_ignore");
    cycle(5'h10, 1'b0, 1'b0, "release_wait");
    cycle(5'h00, 1'b0, 1'b0, "release_idle");

    cycle(5'h02, 1'b1, 1'b0, "configuration");
    cycle(5'h02, 1'b0, 1'b0, "configuration_hold");

    cycle(5'h10, 1'b1, 1'b0, "wrreg_strobe");
    repeat (20) cycle(5'h10, 1'b0, 1'b0, "wrreg_held");

    cycle(5'h10, 1'b1, 1'b0, "wrreg_then_ecr");
    cycle(5'h12, 1'b1, 1'b0, "ecr_dropped");
    repeat (4) cycle(5'h12, 1'b0, 1'b0, "after_drop");

    cycle(5'h00, 1'b0, 1'b1, "tlr_clear1");
    cycle(5'h14, 1'b1, 1'b0, "halt_strobe");
    cycle(5'h00, 1'b0, 1'b0, "halt_gap");
    cycle(5'h15, 1'b1, 1'b0, "resume_last_cycle");
    cycle(5'h16, 1'b1, 1'b0, "step_after_pulse");
    repeat (3) cycle(5'h16, 1'b0, 1'b0, "step_tail");

    cycle(5'h03, 1'b1, 1'b0, "extestser");
    cycle(5'h04, 1'b1, 1'b0, "extestdac");
    cycle(5'h05, 1'b1, 1'b0, "sample");
    cycle(5'h04, 1'b1, 1'b0, "extestdac2");
    cycle(5'h03, 1'b1, 1'b1, "tlr_beats_extest");

    repeat (300) cycle(5'h1E, 1'b1, 1'b0, "unmapped_sat");
    checks++;
    assert (o_ill_cnt === 8'hFF && o_illegal === 1'b1) else begin
      failures++; $error("FAIL sat_end ill_cnt got=%0d illegal=%b exp=255/1", o_ill_cnt, o_illegal);
    end
    cycle(5'h1E, 1'b0, 1'b1, "tlr_clear2");

    cycle(5'h10, 1'b1, 1'b0, "pulse_start");
    cycle(5'h10, 1'b0, 1'b0, "pulse_mid");
    #2 i_trst_n = 1'b0;
    #1 model_reset();
    check_all("trst_async");
    @(negedge i_tck);
    cycle(5'h10, 1'b0, 1'b0, "in_reset");
    i_trst_n = 1'b1; m_hold = 2;
    repeat (10) cycle(5'h10, 1'b0, 1'b0, "post_reset");

    for (int n = 0; n < 500; n++) begin
      op  = int'($urandom_range(0, 31));
      upd = ($urandom_range(0, 2) != 0);
      tlr = ($urandom_range(0, 29) == 0);
      cycle(op, upd, tlr, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
